reg_writeback_queue: RTL and testbench



---
 rtl/regwb_pkg.sv | 10 +
 rtl/regwb_fifo.sv | 84 ++++++++
 rtl/reg_writeback_queue.sv | 110 +++++++++++
 tb/tb_reg_writeback_queue.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// Shared types and constants for the register write-back queue.
package regwb_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/regwb_fifo.sv
// Circular write-back entry store: two ordered pushes and one pop per cycle.
// With REGWB_FWD_EN defined, it also provides a youngest-match lookup on two read ports.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iPushA,
  input  wb_entry_t        iEntryA,
  input  logic             iPushB,
  input  wb_entry_t        iEntryB,
  input  logic             iPop,
  output wb_entry_t        oHead,
  output logic [CNT_W-1:0] oCount
`ifdef REGWB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0] iRs1Addr,
  input  logic [REG_ADDR_W-1:0] iRs2Addr,
  output logic                  oFwd1Hit,
  output logic                  oFwd2Hit,
  output logic [XLEN-1:0]       oFwd1Data,
  output logic [XLEN-1:0]       oFwd2Data
`endif
);

  wb_entry_t        r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PW-1:0]    w_tail_p1;

  assign w_tail_p1 = r_tail + PW'(1);

  always_ff @(posedge iClk) begin
    if (iPushA) r_mem[r_tail]    <= iEntryA;
    if (iPushB) r_mem[w_tail_p1] <= iEntryB;
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(iPop);
      r_tail  <= r_tail + PW'(iPushA) + PW'(iPushB);
      r_count <= r_count + CNT_W'(iPushA) + CNT_W'(iPushB) - CNT_W'(iPop);
    end
  end

  assign oHead  = r_mem[r_head];
  assign oCount = r_count;

`ifdef REGWB_FWD_EN
  logic [PW-1:0] w_idx;

  // The scan walks from oldest to youngest, so the last match wins.
  always_comb begin
    oFwd1Hit  = 1'b0;
    oFwd2Hit  = 1'b0;
    oFwd1Data = '0;
    oFwd2Data = '0;
    w_idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (CNT_W'(i) < r_count) begin
        if (iRs1Addr != '0 && r_mem[w_idx].rd == iRs1Addr) begin
          oFwd1Hit  = 1'b1;
          oFwd1Data = r_mem[w_idx].data;
        end
        if (iRs2Addr != '0 && r_mem[w_idx].rd == iRs2Addr) begin
          oFwd2Hit  = 1'b1;
          oFwd2Data = r_mem[w_idx].data;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/reg_writeback_queue.sv
// Register-file write front end: result handshake, x0 filter, pending-write scoreboard.
// Optional forwarding ports are enabled by REGWB_FWD_EN.
module reg_writeback_queue
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned XLEN   = regwb_pkg::XLEN,
  parameter int unsigned ADDR_W = regwb_pkg::REG_ADDR_W,
  localparam int unsigned NREG  = 1 << ADDR_W
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iLdValid,
  output logic              oLdReady,
  input  logic [ADDR_W-1:0] iLdRd,
  input  logic [XLEN-1:0]   iLdData,
  input  logic              iAluValid,
  output logic              oAluReady,
  input  logic [ADDR_W-1:0] iAluRd,
  input  logic [XLEN-1:0]   iAluData,
  input  logic              iIssueEn,
  input  logic [ADDR_W-1:0] iIssueRd,
  output logic [NREG-1:0]   oBusy,
  output logic              oWriteEn,
  output logic [ADDR_W-1:0] oRdAddr,
  output logic [XLEN-1:0]   oWriteData
`ifdef REGWB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] iRs1Addr,
  input  logic [ADDR_W-1:0] iRs2Addr,
  output logic              oFwd1Hit,
  output logic              oFwd2Hit,
  output logic [XLEN-1:0]   oFwd1Data,
  output logic [XLEN-1:0]   oFwd2Data
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_free;
  logic             w_pop;
  logic             w_ld_keep;
  logic             w_alu_keep;
  logic             w_push_a;
  logic             w_push_b;
  wb_entry_t        w_entry_a;
  wb_entry_t        w_entry_ld;
  wb_entry_t        w_entry_alu;
  wb_entry_t        w_head;
  logic [NREG-1:0]  r_busy;
  logic [NREG-1:0]  w_busy_nxt;

  assign w_pop  = (w_count != '0);
  assign w_free = CNT_W'(DEPTH) - w_count + CNT_W'(w_pop);

  assign oLdReady  = (w_free >= CNT_W'(1));
  assign oAluReady = (w_free >= CNT_W'(2)) | ((w_free >= CNT_W'(1)) & ~iLdValid);

  assign w_ld_keep  = iLdValid  & oLdReady  & (iLdRd  != '0);
  assign w_alu_keep = iAluValid & oAluReady & (iAluRd != '0);

  assign w_entry_ld  = '{rd: iLdRd,  data: iLdData};
  assign w_entry_alu = '{rd: iAluRd, data: iAluData};

  // Survivors are packed onto port A first so a lone ALU result never leaves a hole.
  assign w_push_a  = w_ld_keep | w_alu_keep;
  assign w_push_b  = w_ld_keep & w_alu_keep;
  assign w_entry_a = w_ld_keep ? w_entry_ld : w_entry_alu;

  regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iPushA  (w_push_a),
    .iEntryA (w_entry_a),
    .iPushB  (w_push_b),
    .iEntryB (w_entry_alu),
    .iPop    (w_pop),
    .oHead   (w_head),
    .oCount  (w_count)
`ifdef REGWB_FWD_EN
    ,
    .iRs1Addr  (iRs1Addr),
    .iRs2Addr  (iRs2Addr),
    .oFwd1Hit  (oFwd1Hit),
    .oFwd2Hit  (oFwd2Hit),
    .oFwd1Data (oFwd1Data),
    .oFwd2Data (oFwd2Data)
`endif
  );

  // Clear then set, so a same-cycle reissue of the retiring rd stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop && w_head.rd != '0) w_busy_nxt[w_head.rd] = 1'b0;
    if (iIssueEn && iIssueRd != '0) w_busy_nxt[iIssueRd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign oBusy      = r_busy;
  assign oWriteEn   = w_pop;
  assign oRdAddr    = w_pop ? w_head.rd   : '0;
  assign oWriteData = w_pop ? w_head.data : '0;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed plus random bench for reg_writeback_queue against a queue-based reference model.
module tb_reg_writeback_queue;
  localparam int unsigned DEPTH = 4;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iLdValid, oLdReady, iAluValid, oAluReady, iIssueEn, oWriteEn;
  logic [4:0]  iLdRd, iAluRd, iIssueRd, oRdAddr;
  logic [31:0] iLdData, iAluData, oWriteData, oBusy;
`ifdef REGWB_FWD_EN
  logic [4:0]  iRs1Addr, iRs2Addr;
  logic        oFwd1Hit, oFwd2Hit;
  logic [31:0] oFwd1Data, oFwd2Data;
`endif

  always #5 iClk = ~iClk;

  reg_writeback_queue #(.DEPTH(DEPTH), .XLEN(32), .ADDR_W(5)) dut (
    .iClk(iClk), .iRstN(iRstN),
    .iLdValid(iLdValid), .oLdReady(oLdReady), .iLdRd(iLdRd), .iLdData(iLdData),
    .iAluValid(iAluValid), .oAluReady(oAluReady), .iAluRd(iAluRd), .iAluData(iAluData),
    .iIssueEn(iIssueEn), .iIssueRd(iIssueRd), .oBusy(oBusy),
    .oWriteEn(oWriteEn), .oRdAddr(oRdAddr), .oWriteData(oWriteData)
`ifdef REGWB_FWD_EN
    , .iRs1Addr(iRs1Addr), .iRs2Addr(iRs2Addr), .oFwd1Hit(oFwd1Hit), .oFwd2Hit(oFwd2Hit),
    .oFwd1Data(oFwd1Data), .oFwd2Data(oFwd2Data)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_busy;
  int          n_vec = 0;
  int          n_err = 0;
  logic        g_alu_rdy_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef REGWB_FWD_EN
  function automatic logic [32:0] fwd_ref(input logic [4:0] a);
    fwd_ref = '0;
    if (a != 5'd0)
      for (int k = m_q.size() - 1; k >= 0; k--)
        if (m_q[k].rd == a) return {1'b1, m_q[k].data};
  endfunction
`endif

  // One clock: drive, check at the falling edge, then advance the model at the rising edge.
  task automatic step(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic ie, input logic [4:0] ird);
    int unsigned sz, fr;
    logic        e_ldr, e_alr;
    iLdValid = lv;  iLdRd = lrd;  iLdData = ldat;
    iAluValid = av; iAluRd = ard; iAluData = adat;
    iIssueEn = ie;  iIssueRd = ird;
`ifdef REGWB_FWD_EN
    iRs1Addr = 5'($urandom_range(0, 31));
    iRs2Addr = (m_q.size() != 0) ? m_q[$urandom_range(0, m_q.size() - 1)].rd : 5'd0;
`endif
    @(negedge iClk);
    sz    = m_q.size();
    fr    = DEPTH - sz + ((sz != 0) ? 1 : 0);
    e_ldr = (fr >= 1);
    e_alr = (fr >= 2) || ((fr >= 1) && !lv);
    g_alu_rdy_obs = oAluReady;
    chk("ld_ready",  oLdReady,   e_ldr);
    chk("alu_ready", oAluReady,  e_alr);
    chk("wr_en",     oWriteEn,   sz != 0);
    chk("rd_addr",   oRdAddr,    (sz != 0) ? m_q[0].rd : 5'd0);
    chk("wr_data",   oWriteData, (sz != 0) ? m_q[0].data : 32'd0);
    chk("busy",      oBusy,      m_busy);
`ifdef REGWB_FWD_EN
    chk("fwd1_hit",  oFwd1Hit,  fwd_ref(iRs1Addr)[32]);
    chk("fwd1_data", oFwd1Data, fwd_ref(iRs1Addr)[31:0]);
    chk("fwd2_hit",  oFwd2Hit,  fwd_ref(iRs2Addr)[32]);
    chk("fwd2_data", oFwd2Data, fwd_ref(iRs2Addr)[31:0]);
`endif
    @(posedge iClk);
    if (!iRstN) begin
      m_q.delete();
      m_busy = '0;
    end else begin
      if (sz != 0) begin
        m_busy[m_q[0].rd] = 1'b0;
        void'(m_q.pop_front());
      end
      if (ie && ird != 5'd0) m_busy[ird] = 1'b1;
      if (lv && e_ldr && lrd != 5'd0) m_q.push_back('{lrd, ldat});
      if (av && e_alr && ard != 5'd0) m_q.push_back('{ard, adat});
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    m_busy = '0;
    iRstN  = 1'b0;
    idle();
    idle();
    iRstN = 1'b1;
    idle();

    // Single ALU write appears for exactly one cycle.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 5'd0);
    chk("single_wen",  oWriteEn,   1'b1);
    chk("single_rd",   oRdAddr,    5'd1);
    chk("single_data", oWriteData, 32'hDEADBEEF);
    idle();
    chk("single_once", oWriteEn, 1'b0);

    // Dual accept: load is older.
    step(1'b1, 5'd5, 32'hCAFEBABE, 1'b1, 5'd10, 32'hABCD1234, 1'b0, 5'd0);
    chk("dual_first", oRdAddr, 5'd5);
    idle();
    chk("dual_second", oRdAddr, 5'd10);
    chk("dual_second_data", oWriteData, 32'hABCD1234);
    idle();

    // Backpressure: four cycles of dual pushes into a 4-deep queue.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 5'(k + 1), 32'h1000 + 32'(k), 1'b1, 5'(k + 11), 32'h2000 + 32'(k), 1'b0, 5'd0);
      if (k == 3) chk("bp_alu_drop", g_alu_rdy_obs, 1'b0);
    end
    for (int k = 0; k < 6; k++) idle();

    // x0 filter on both result and issue.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0);
    chk("x0_wen",  oWriteEn, 1'b0);
    chk("x0_busy", oBusy, 32'd0);

    // Scoreboard: reissue of rd 7 in the cycle it retires keeps it busy.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77777777, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    chk("sb_busy7", oBusy[7], 1'b1);
    idle();

    // Reset with three entries in flight.
    step(1'b1, 5'd2, 32'hA2, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd2);
    step(1'b1, 5'd4, 32'hA4, 1'b1, 5'd6, 32'hA6, 1'b1, 5'd4);
    iRstN = 1'b0;
    idle();
    iRstN = 1'b1;
    chk("rst_wen",   oWriteEn,  1'b0);
    chk("rst_busy",  oBusy,     32'd0);
    chk("rst_ldrdy", oLdReady,  1'b1);
    chk("rst_alurdy", oAluReady, 1'b1);
    idle();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
    end
    for (int k = 0; k < 6; k++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
